// File: rtl/i_fab_pkg.sv
// rtl/i_fab_pkg.sv - shared constants and helpers for the fabric ingress cell
//
// Purpose: default parameter values for i_fab_ingress and a saturating
// increment used by its transition counter.
// Ports: none (package).

package i_fab_pkg;

  localparam int   DEF_WIDTH      = 1;
  localparam int   DEF_CNT_WIDTH  = 16;
  localparam logic DEF_INIT_VALUE = 1'b0;

  // Widest counter the helper below can carry.
  localparam int   MAX_CNT_WIDTH  = 32;

  // Returns value+1 unless value already equals max_value, in which case it
  // holds. Callers zero-extend into and truncate out of the 32-bit carrier.
  function automatic logic [MAX_CNT_WIDTH-1:0] sat_inc(
    input logic [MAX_CNT_WIDTH-1:0] value,
    input logic [MAX_CNT_WIDTH-1:0] max_value
  );
    if (value == max_value) begin
      return value;
    end
    return value + 32'd1;
  endfunction

endpackage

// File: rtl/i_fab_edge_det.sv
// rtl/i_fab_edge_det.sv - per-bit previous-sample register and edge pulses
//
// Purpose: samples din every rising clk and produces one-cycle rise/fall
// pulses from the comparison of the new sample against the previous one.
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset
//   din   in   WIDTH  data being observed
//   prev  out  WIDTH  last sampled din (reset value {WIDTH{INIT_VALUE}})
//   rise  out  WIDTH  pulse on a sampled 0->1 transition
//   fall  out  WIDTH  pulse on a sampled 1->0 transition

module i_fab_edge_det
  import i_fab_pkg::*;
#(
  parameter int   WIDTH      = DEF_WIDTH,
  parameter logic INIT_VALUE = DEF_INIT_VALUE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] prev,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= {WIDTH{INIT_VALUE}};
      rise <= '0;
      fall <= '0;
    end else begin
      prev <= din;
      // Compared against the old prev, so a pulse lasts one cycle unless
      // din toggles again.
      rise <= din & ~prev;
      fall <= ~din & prev;
    end
  end

endmodule

// File: rtl/i_fab_ingress.sv
// rtl/i_fab_ingress.sv - fabric-side input buffer cell with debug observability
//
// Purpose: passes I straight through to O combinationally, and alongside it
// keeps a registered copy, edge pulses and a saturating transition counter.
// Ports:
//   C           in   rising-edge clock
//   R           in   asynchronous active-high reset
//   CNT_CLR     in   synchronous clear of TOGGLE_CNT (wins over a change)
//   I           in   WIDTH      fabric input data
//   O           out  WIDTH      combinational copy of I, unaffected by C/R
//   O_REG       out  WIDTH      I registered on rising C
//   RISE        out  WIDTH      per-bit 0->1 pulse
//   FALL        out  WIDTH      per-bit 1->0 pulse
//   TOGGLE_CNT  out  CNT_WIDTH  sampled cycles in which any bit of I changed
//                               (saturating; CNT_WIDTH must not exceed 32)

module i_fab_ingress
  import i_fab_pkg::*;
#(
  parameter int   WIDTH      = DEF_WIDTH,
  parameter logic INIT_VALUE = DEF_INIT_VALUE,
  parameter int   CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                 C,
  input  logic                 R,
  input  logic                 CNT_CLR,
  input  logic [WIDTH-1:0]     I,
  output logic [WIDTH-1:0]     O,
  output logic [WIDTH-1:0]     O_REG,
  output logic [WIDTH-1:0]     RISE,
  output logic [WIDTH-1:0]     FALL,
  output logic [CNT_WIDTH-1:0] TOGGLE_CNT
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] prev;
  logic             change;

  // Plain wire: X/Z on I reaches O untouched, and reset has no say here.
  assign O = I;

  i_fab_edge_det #(
    .WIDTH      (WIDTH),
    .INIT_VALUE (INIT_VALUE)
  ) u_edge_det (
    .clk  (C),
    .rst  (R),
    .din  (I),
    .prev (prev),
    .rise (RISE),
    .fall (FALL)
  );

  // The previous-sample register already is "I delayed by one cycle" with
  // the right reset value, so it doubles as the registered output.
  assign O_REG  = prev;
  assign change = (I != prev);

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      TOGGLE_CNT <= '0;
    end else if (CNT_CLR) begin
      TOGGLE_CNT <= '0;
    end else if (change) begin
      TOGGLE_CNT <= CNT_WIDTH'(sat_inc(MAX_CNT_WIDTH'(TOGGLE_CNT),
                                       MAX_CNT_WIDTH'(CNT_MAX)));
    end
  end

endmodule

// File: tb/tb_i_fab_ingress.sv
// tb/tb_i_fab_ingress.sv - directed self-checking bench for i_fab_ingress

module tb_i_fab_ingress;

  logic        C = 1'b0;
  logic        R = 1'b0;
  logic        CNT_CLR = 1'b0;
  logic        run = 1'b0;

  // Default instance: WIDTH=1, INIT_VALUE=0, CNT_WIDTH=16.
  logic [0:0]  I = 1'b0;
  logic [0:0]  O, O_REG, RISE, FALL;
  logic [15:0] cnt;

  // Second instance: WIDTH=4, INIT_VALUE=1, CNT_WIDTH=4 (saturation).
  logic [3:0]  I4 = 4'b0000;
  logic [3:0]  O4, O_REG4, RISE4, FALL4;
  logic [3:0]  cnt4;

  int total = 0;
  int bad = 0;

  i_fab_ingress dut (
    .C(C), .R(R), .CNT_CLR(CNT_CLR), .I(I), .O(O), .O_REG(O_REG),
    .RISE(RISE), .FALL(FALL), .TOGGLE_CNT(cnt)
  );

  i_fab_ingress #(.WIDTH(4), .INIT_VALUE(1'b1), .CNT_WIDTH(4)) dut_s (
    .C(C), .R(R), .CNT_CLR(CNT_CLR), .I(I4), .O(O4), .O_REG(O_REG4),
    .RISE(RISE4), .FALL(FALL4), .TOGGLE_CNT(cnt4)
  );

  always begin
    #5;
    if (run) C = ~C;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  logic [0:0] s4_i    [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [0:0] s4_rise [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [0:0] s4_fall [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [3:0] w4_i    [4] = '{4'b0101, 4'b0110, 4'b0110, 4'b1001};
  logic [3:0] w4_rise [4] = '{4'b0101, 4'b0010, 4'b0000, 4'b1001};
  logic [3:0] w4_fall [4] = '{4'b0000, 4'b0001, 4'b0000, 4'b0110};
  logic [3:0] w4_cnt  [4] = '{4'd2, 4'd3, 4'd3, 4'd4};

  initial begin
    int bad_before;

    // 1: pass-through with the clock idle, including an X value.
    bad_before = bad;
    #3 I = 1'b0; #1 check("pass_0", O, 1'b0);
    #2 I = 1'b1; #1 check("pass_1", O, 1'b1);
    for (int k = 0; k < 64; k++) begin
      #2 I = 1'($urandom_range(0, 1));
      I4 = 4'($urandom_range(0, 15));
      #1 check("pass_rand", O, I);
      check("pass_rand4", O4, I4);
    end
    #2 I = 1'bx; #1 check("pass_x", O, 1'bx);
    if (bad == bad_before) $display("step1 passthrough PASSED");

    // 2: reset held with I=1.
    I = 1'b1; I4 = 4'b0000;
    R = 1'b1;
    #1 check("rst_o", O, 1'b1);
    check("rst_oreg", O_REG, 1'b0);
    check("rst_rise", RISE, 1'b0);
    check("rst_fall", FALL, 1'b0);
    check("rst_cnt", cnt, 16'd0);
    check("rst_oreg4", O_REG4, 4'b1111);
    check("rst_cnt4", cnt4, 4'd0);
    run = 1'b1;
    tick(); tick();
    check("rst_hold_oreg", O_REG, 1'b0);
    check("rst_hold_rise", RISE, 1'b0);
    check("rst_hold_cnt", cnt, 16'd0);
    check("rst_hold_oreg4", O_REG4, 4'b1111);

    // 3: release with I differing from INIT_VALUE.
    @(negedge C); R = 1'b0;
    tick();
    check("rel_rise", RISE, 1'b1);
    check("rel_cnt", cnt, 16'd1);
    check("rel_oreg", O_REG, 1'b1);
    check("rel_fall4", FALL4, 4'b1111);
    check("rel_rise4", RISE4, 4'b0000);
    check("rel_cnt4", cnt4, 4'd1);
    check("rel_oreg4", O_REG4, 4'b0000);
    tick();
    check("rel2_rise", RISE, 1'b0);
    check("rel2_cnt", cnt, 16'd1);
    check("rel2_fall4", FALL4, 4'b0000);
    check("rel2_cnt4", cnt4, 4'd1);

    // 4: alternating toggles, then clear colliding with a change.
    for (int k = 0; k < 4; k++) begin
      I = s4_i[k]; I4 = w4_i[k];
      tick();
      check("tog_rise", RISE, s4_rise[k]);
      check("tog_fall", FALL, s4_fall[k]);
      check("tog_cnt", cnt, 16'(k + 2));
      check("tog_oreg", O_REG, s4_i[k]);
      check("tog_rise4", RISE4, w4_rise[k]);
      check("tog_fall4", FALL4, w4_fall[k]);
      check("tog_cnt4", cnt4, w4_cnt[k]);
    end
    I = 1'b0; I4 = 4'b0000; CNT_CLR = 1'b1;
    tick();
    check("clr_cnt", cnt, 16'd0);
    check("clr_fall", FALL, 1'b1);
    check("clr_cnt4", cnt4, 4'd0);
    check("clr_fall4", FALL4, 4'b1001);
    CNT_CLR = 1'b0;
    tick();
    check("clr_hold_cnt", cnt, 16'd0);
    check("clr_hold_fall", FALL, 1'b0);

    // 5: 20 toggles; the 4-bit counter pins at 15.
    for (int k = 1; k <= 20; k++) begin
      I = ~I; I4 = ~I4;
      tick();
      check("sat_cnt", cnt, 16'(k));
      check("sat_cnt4", cnt4, (k > 15) ? 4'd15 : 4'(k));
    end

    // 6: asynchronous reset between edges.
    I = 1'b1; I4 = 4'b1111;
    tick();
    check("pre_oreg", O_REG, 1'b1);
    check("pre_rise", RISE, 1'b1);
    check("pre_cnt", cnt, 16'd21);
    check("pre_cnt4", cnt4, 4'd15);
    I = 1'b0; I4 = 4'b0000;
    #2 R = 1'b1;
    #1 check("async_oreg", O_REG, 1'b0);
    check("async_rise", RISE, 1'b0);
    check("async_cnt", cnt, 16'd0);
    check("async_o", O, 1'b0);
    check("async_oreg4", O_REG4, 4'b1111);
    check("async_fall4", FALL4, 4'b0000);
    check("async_cnt4", cnt4, 4'd0);
    I = 1'b1;
    #1 check("async_o_track", O, 1'b1);
    I = 1'b0; I4 = 4'b1111;
    @(negedge C); R = 1'b0;
    tick();
    check("post_rise", RISE, 1'b0);
    check("post_fall", FALL, 1'b0);
    check("post_cnt", cnt, 16'd0);
    check("post_rise4", RISE4, 4'b0000);
    check("post_fall4", FALL4, 4'b0000);
    check("post_cnt4", cnt4, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
